// File: rtl/alarm_clock_multi.sv
// 24-hour time-of-day clock with an exact 1 s prescaler and NUM_ALARMS alarm slots,
// with snooze, ring timeout and validation of BCD time/alarm loads.
module alarm_clock_multi #(
  parameter int CLK_DIV        = 10,
  parameter int NUM_ALARMS     = 4,
  parameter int SNOOZE_S       = 300,
  parameter int RING_TIMEOUT_S = 60,
  localparam int SEL_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            H_in1,
  input  logic [3:0]            H_in0,
  input  logic [3:0]            M_in1,
  input  logic [3:0]            M_in0,
  input  logic                  LD_time,
  input  logic                  LD_alarm,
  input  logic [SEL_W-1:0]      AL_sel,
  input  logic [NUM_ALARMS-1:0] AL_ON,
  input  logic                  STOP_al,
  input  logic                  SNOOZE,
  output logic                  Alarm,
  output logic [SEL_W-1:0]      alarm_id,
  output logic                  snoozed,
  output logic                  tick_1s,
  output logic                  load_err,
  output logic [1:0]            H_out1,
  output logic [3:0]            H_out0,
  output logic [3:0]            M_out1,
  output logic [3:0]            M_out0,
  output logic [3:0]            S_out1,
  output logic [3:0]            S_out0
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int RW = $clog2(RING_TIMEOUT_S + 1);
  localparam int SW = $clog2(SNOOZE_S + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [RW-1:0] RING_LAST  = RW'(RING_TIMEOUT_S - 1);
  localparam logic [SW-1:0] SNZ_LOAD   = SW'(SNOOZE_S);

  typedef enum logic [1:0] {ST_IDLE, ST_RING, ST_SNZ} state_e;

  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    sec_q, sec_d;
  logic [5:0]    min_q, min_d;
  logic [4:0]    hour_q, hour_d;
  logic          load_err_q;
  logic [4:0]    al_hour_q [NUM_ALARMS];
  logic [5:0]    al_min_q  [NUM_ALARMS];

  state_e           state_q;
  logic [RW-1:0]    ring_cnt_q;
  logic [SW-1:0]    snz_cnt_q;
  logic [SEL_W-1:0] alarm_id_q;

  logic             tick;
  logic             roll;
  logic [5:0]       hour_in;
  logic [7:0]       min_in;
  logic             in_valid;
  logic             sel_ok;
  logic             match_hit;
  logic [SEL_W-1:0] match_idx;

  assign tick = (presc_q == PRESC_LAST);

  // BCD digits are recombined into binary so range checks are a single compare.
  assign hour_in  = 6'(H_in1) * 6'd10 + 6'(H_in0);
  assign min_in   = 8'(M_in1) * 8'd10 + 8'(M_in0);
  assign in_valid = (H_in0 <= 4'd9) && (M_in1 <= 4'd9) && (M_in0 <= 4'd9) &&
                    (hour_in <= 6'd23) && (min_in <= 8'd59);

  always_comb begin
    sel_ok = 1'b0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (AL_sel == SEL_W'(i)) sel_ok = 1'b1;
    end
  end

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    roll    = 1'b0;
    if (tick) begin
      if (sec_q == 6'd59) begin
        sec_d = '0;
        roll  = 1'b1;
        if (min_q == 6'd59) begin
          min_d  = '0;
          hour_d = (hour_q == 5'd23) ? '0 : hour_q + 5'd1;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end
    // A valid time load wins over the tick and can never raise a match.
    if (LD_time && in_valid) begin
      hour_d  = hour_in[4:0];
      min_d   = min_in[5:0];
      sec_d   = '0;
      presc_d = '0;
      roll    = 1'b0;
    end
  end

  // Downward scan so the lowest matching slot is the one left standing.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (roll && AL_ON[i] && (al_hour_q[i] == hour_d) && (al_min_q[i] == min_d)) begin
        match_hit = 1'b1;
        match_idx = SEL_W'(i);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q    <= '0;
      sec_q      <= '0;
      min_q      <= '0;
      hour_q     <= '0;
      load_err_q <= 1'b0;
      // NOTE: the alarm slots are a register file that must read 00:00 after reset, so they are reset too.
      for (int i = 0; i < NUM_ALARMS; i++) begin
        al_hour_q[i] <= '0;
        al_min_q[i]  <= '0;
      end
    end else begin
      presc_q    <= presc_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hour_q     <= hour_d;
      load_err_q <= (LD_time && !in_valid) || (LD_alarm && !(in_valid && sel_ok));
      if (LD_alarm && in_valid && sel_ok) begin
        al_hour_q[AL_sel] <= hour_in[4:0];
        al_min_q[AL_sel]  <= min_in[5:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
      alarm_id_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (match_hit) begin
            state_q    <= ST_RING;
            alarm_id_q <= match_idx;
            ring_cnt_q <= '0;
          end
        end
        ST_RING: begin
          if (STOP_al) begin
            state_q <= ST_IDLE;
          end else if (SNOOZE) begin
            state_q   <= ST_SNZ;
            snz_cnt_q <= SNZ_LOAD;
          end else if (tick) begin
            if (ring_cnt_q == RING_LAST) state_q <= ST_IDLE;
            else                         ring_cnt_q <= ring_cnt_q + RW'(1);
          end
        end
        ST_SNZ: begin
          if (STOP_al) begin
            state_q <= ST_IDLE;
          end else if (match_hit) begin
            state_q    <= ST_RING;
            alarm_id_q <= match_idx;
            ring_cnt_q <= '0;
          end else if (tick) begin
            if (snz_cnt_q == SW'(1)) begin
              state_q    <= ST_RING;
              ring_cnt_q <= '0;
            end
            snz_cnt_q <= snz_cnt_q - SW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign Alarm    = (state_q == ST_RING);
  assign snoozed  = (state_q == ST_SNZ);
  assign alarm_id = alarm_id_q;
  assign tick_1s  = tick;
  assign load_err = load_err_q;

  assign H_out1 = 2'(hour_q / 5'd10);
  assign H_out0 = 4'(hour_q % 5'd10);
  assign M_out1 = 4'(min_q / 6'd10);
  assign M_out0 = 4'(min_q % 6'd10);
  assign S_out1 = 4'(sec_q / 6'd10);
  assign S_out0 = 4'(sec_q % 6'd10);

endmodule
